// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a latched pattern MSB-first, optionally repeating with idle gaps.
// Optional macro SEQ_PATTERN_TX_SEG_EN builds the registered 7-segment decode of the frame counter.
module seq_pattern_tx #(
    parameter int GAP = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ena,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [7:0] i_pattern,
    input  logic [3:0] i_len,
    input  logic [3:0] i_repeat,
    output logic       o_serial_out,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_frame_cnt,
    output logic [7:0] o_seg
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t          r_state;
    logic [7:0]      r_pat;
    logic [2:0]      r_len_m1;
    logic [2:0]      r_idx;
    logic [3:0]      r_remain;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_frame_end;
    logic            r_serial;
    logic            r_busy;
    logic            r_done;
    logic [3:0]      r_frame_cnt;

    logic [2:0]      w_len_m1;
    logic [3:0]      w_cnt_next;

    // Lengths of 0 or above 8 behave as a full 8-bit frame.
    assign w_len_m1   = (i_len == 4'd0 || i_len > 4'd8) ? 3'd7 : 3'(i_len - 4'd1);
    assign w_cnt_next = (r_frame_cnt >= 4'd9) ? 4'd0 : r_frame_cnt + 4'd1;

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_pat       <= 8'h00;
            r_len_m1    <= 3'd0;
            r_idx       <= 3'd0;
            r_remain    <= 4'd0;
            r_gap_cnt   <= '0;
            r_frame_end <= 1'b0;
            r_serial    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= 4'd0;
        end else if (i_ena) begin
            // The count lands one cycle after a frame's last bit, even if an abort follows.
            if (r_frame_end) begin
                r_frame_end <= 1'b0;
                r_frame_cnt <= w_cnt_next;
            end
            case (r_state)
                S_IDLE: begin
                    r_serial <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    if (i_start && !i_abort) begin
                        r_pat    <= i_pattern;
                        r_len_m1 <= w_len_m1;
                        r_idx    <= w_len_m1;
                        r_remain <= i_repeat;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (i_abort) begin
                        r_serial <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_serial <= r_pat[r_idx];
                        r_busy   <= 1'b1;
                        if (r_idx == 3'd0) begin
                            r_frame_end <= 1'b1;
                            r_idx       <= r_len_m1;
                            // r_remain of 0 means continuous; 1 means this was the final frame.
                            if (r_remain != 4'd1) begin
                                if (r_remain != 4'd0) begin
                                    r_remain <= r_remain - 4'd1;
                                end
                                if (GAP == 0) begin
                                    r_state <= S_SHIFT;
                                end else begin
                                    r_gap_cnt <= '0;
                                    r_state   <= S_GAP;
                                end
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_idx <= r_idx - 3'd1;
                        end
                    end
                end
                S_GAP: begin
                    r_serial <= 1'b0;
                    if (i_abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_SHIFT;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                S_DONE: begin
                    r_serial <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_serial_out = r_serial;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_frame_cnt  = r_frame_cnt;

`ifdef SEQ_PATTERN_TX_SEG_EN
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return 8'hFD;
            4'd1:    return 8'hC1;
            4'd2:    return 8'h6F;
            4'd3:    return 8'hE7;
            4'd4:    return 8'hD3;
            4'd5:    return 8'hB7;
            4'd6:    return 8'hBF;
            4'd7:    return 8'hE1;
            4'd8:    return 8'hFF;
            4'd9:    return 8'hF7;
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0] r_seg;

    // Updated on the same edge as r_frame_cnt so the display never lags the count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_seg <= 8'hFD;
        end else if (i_ena && r_frame_end) begin
            r_seg <= seg_decode(w_cnt_next);
        end
    end

    assign o_seg = r_seg;
`else
    assign o_seg = 8'h00;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx (GAP=2), with hand-derived expected sequences.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pattern = 8'h00;
    logic [3:0] len = 4'd0;
    logic [3:0] rep = 4'd0;
    logic       serial_out;
    logic       busy;
    logic       done;
    logic [3:0] frame_cnt;
    logic [7:0] seg;

    int total = 0;
    int bad = 0;

    seq_pattern_tx #(.GAP(2)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ena        (ena),
        .i_start      (start),
        .i_abort      (abort),
        .i_pattern    (pattern),
        .i_len        (len),
        .i_repeat     (rep),
        .o_serial_out (serial_out),
        .o_busy       (busy),
        .o_done       (done),
        .o_frame_cnt  (frame_cnt),
        .o_seg        (seg)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [7:0] exp_seg(input int n);
`ifdef SEQ_PATTERN_TX_SEG_EN
        case (n)
            0: return 8'hFD;
            1: return 8'hC1;
            2: return 8'h6F;
            3: return 8'hE7;
            4: return 8'hD3;
            5: return 8'hB7;
            6: return 8'hBF;
            7: return 8'hE1;
            8: return 8'hFF;
            9: return 8'hF7;
            default: return 8'h00;
        endcase
`else
        return (n > 99) ? 8'h00 : 8'h00;
`endif
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (serial_out !== 1'b0) begin bad++; $display("FAIL reset_serial: got %b want 0", serial_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (frame_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
        total++; if (seg !== exp_seg(0)) begin bad++; $display("FAIL reset_seg: got %h want %h", seg, exp_seg(0)); end
    endtask

    task automatic test_single();
        logic [3:0] bits = 4'b1001;
        do_reset();
        pattern = 8'h09; len = 4'd4; rep = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        total++; if (busy !== 1'b0 || serial_out !== 1'b0) begin bad++; $display("FAIL single_accept: busy=%b serial=%b want 0 0", busy, serial_out); end
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (serial_out !== bits[3-k]) begin bad++; $display("FAIL single_bit%0d: got %b want %b", k, serial_out, bits[3-k]); end
            total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL single_busy%0d: busy=%b done=%b want 1 0", k, busy, done); end
        end
        step();
        total++; if (done !== 1'b1 || busy !== 1'b0 || serial_out !== 1'b0) begin bad++; $display("FAIL single_done: done=%b busy=%b serial=%b want 1 0 0", done, busy, serial_out); end
        total++; if (frame_cnt !== 4'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", frame_cnt); end
        total++; if (seg !== exp_seg(1)) begin bad++; $display("FAIL single_seg: got %h want %h", seg, exp_seg(1)); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_repeat();
        logic [15:0] seq = 16'b1001_00_1001_00_1001;
        int ndone = 0;
        do_reset();
        pattern = 8'h09; len = 4'd4; rep = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (done) ndone++;
            total++; if (serial_out !== seq[15-k]) begin bad++; $display("FAIL repeat_bit%0d: got %b want %b", k, serial_out, seq[15-k]); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL repeat_busy%0d: got %b want 1", k, busy); end
            if (k == 4) begin
                total++; if (frame_cnt !== 4'd1) begin bad++; $display("FAIL repeat_cnt_mid: got %0d want 1", frame_cnt); end
            end
        end
        step();
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL repeat_done: done=%b busy=%b want 1 0", done, busy); end
        total++; if (frame_cnt !== 4'd3) begin bad++; $display("FAIL repeat_cnt: got %0d want 3", frame_cnt); end
        total++; if (seg !== exp_seg(3)) begin bad++; $display("FAIL repeat_seg: got %h want %h", seg, exp_seg(3)); end
        for (int k = 0; k < 3; k++) begin
            step();
            if (done) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL repeat_extra_done: got %0d extra pulses want 0", ndone); end
    endtask

    task automatic test_stall();
        do_reset();
        pattern = 8'h0D; len = 4'd4; rep = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL stall_bit0: got %b want 1", serial_out); end
        step();
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL stall_bit1: got %b want 1", serial_out); end
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (serial_out !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL stall_hold%0d: serial=%b busy=%b done=%b want 1 1 0", k, serial_out, busy, done); end
            total++; if (frame_cnt !== 4'd0) begin bad++; $display("FAIL stall_cnt%0d: got %0d want 0", k, frame_cnt); end
        end
        ena = 1'b1;
        step();
        total++; if (serial_out !== 1'b0) begin bad++; $display("FAIL stall_bit2: got %b want 0", serial_out); end
        step();
        total++; if (serial_out !== 1'b1) begin bad++; $display("FAIL stall_bit3: got %b want 1", serial_out); end
        step();
        total++; if (done !== 1'b1 || frame_cnt !== 4'd1) begin bad++; $display("FAIL stall_done: done=%b cnt=%0d want 1 1", done, frame_cnt); end
    endtask

    task automatic test_abort();
        int ndone = 0;
        do_reset();
        pattern = 8'hFF; len = 4'd8; rep = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        total++; if (serial_out !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL abort_pre: serial=%b busy=%b want 1 1", serial_out, busy); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (serial_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_stop: serial=%b busy=%b done=%b want 0 0 0", serial_out, busy, done); end
        total++; if (frame_cnt !== 4'd0) begin bad++; $display("FAIL abort_cnt: got %0d want 0", frame_cnt); end
        for (int k = 0; k < 6; k++) begin
            step();
            if (done || busy) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", ndone); end
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        total++; if (busy !== 1'b0 || serial_out !== 1'b0) begin bad++; $display("FAIL abort_priority: busy=%b serial=%b want 0 0", busy, serial_out); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_ser  = 6'b100001;
        logic [5:0] exp_busy = 6'b110011;
        logic [5:0] exp_done = 6'b001000;
        do_reset();
        pattern = 8'h02; len = 4'd2; rep = 4'd1; start = 1'b1;
        step();
        pattern = 8'h01;
        for (int c = 0; c < 6; c++) begin
            step();
            total++; if (serial_out !== exp_ser[5-c] || busy !== exp_busy[5-c] || done !== exp_done[5-c]) begin
                bad++;
                $display("FAIL b2b_cycle%0d: serial/busy/done=%b%b%b want %b%b%b", c + 1, serial_out, busy, done, exp_ser[5-c], exp_busy[5-c], exp_done[5-c]);
            end
        end
        start = 1'b0;
        step(); step(); step();
        total++; if (frame_cnt !== 4'd2) begin bad++; $display("FAIL b2b_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0] pat = 8'hA5;
        logic       eb;
        int         pos;
        int         ec;
        do_reset();
        pattern = pat; len = 4'd0; rep = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 100; c++) begin
            step();
            pos = (c - 1) % 10;
            eb  = (pos < 8) ? pat[7-pos] : 1'b0;
            ec  = ((c + 1) / 10) % 10;
            total++; if (serial_out !== eb || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL wrap_c%0d: serial=%b busy=%b done=%b want %b 1 0", c, serial_out, busy, done, eb); end
            total++; if (frame_cnt !== 4'(ec) || seg !== exp_seg(ec)) begin bad++; $display("FAIL wrap_cnt_c%0d: cnt=%0d seg=%h want %0d %h", c, frame_cnt, seg, ec, exp_seg(ec)); end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (busy !== 1'b0 || serial_out !== 1'b0 || frame_cnt !== 4'd0 || seg !== exp_seg(0)) begin
            bad++; $display("FAIL wrap_abort: busy=%b serial=%b cnt=%0d seg=%h want 0 0 0 %h", busy, serial_out, frame_cnt, seg, exp_seg(0));
        end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL wrap_no_done: got %b want 0", done); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pattern = 8'h09; len = 4'd4; rep = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        total++; if (frame_cnt !== 4'd1) begin bad++; $display("FAIL rstmid_pre_cnt: got %0d want 1", frame_cnt); end
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        total++; if (serial_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_bit2: serial=%b busy=%b want 0 1", serial_out, busy); end
        rst_n = 1'b0;
        step();
        total++; if (serial_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_outs: serial=%b busy=%b done=%b want 0 0 0", serial_out, busy, done); end
        total++; if (frame_cnt !== 4'd0 || seg !== exp_seg(0)) begin bad++; $display("FAIL rstmid_cnt: cnt=%0d seg=%h want 0 %h", frame_cnt, seg, exp_seg(0)); end
        rst_n = 1'b1;
        step(); step();
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_after: done=%b busy=%b want 0 0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_stall();
        test_abort();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
